imem_fetch_arbiter: RTL
=======================

// Module: imem_fetch_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single instruction_memory read port among NUM_CORES cores.
//  Replaces the OR-ed read_MI_F / core-1-only address drive in top.
//  Sits between the cores' fetch interfaces and instruction_memory.
//  Drives the registered address and read strobe, then returns the word plus a one-hot valid to the winner.
// PARAMETERS
//  NUM_CORES  4   number of requesting cores (2..10)
//  ADDR_W     16  instruction address width
//  DATA_W     16  instruction word width
// PORTS
//  clk        in   1                  clock; all state on posedge
//  RESET      in   1                  synchronous, active-high reset
//  req        in   NUM_CORES          per-core fetch request; hold until rvalid
//  req_addr   in   NUM_CORES*ADDR_W   per-core fetch address; core i at [i*ADDR_W +: ADDR_W]
//  imem_addr  out  ADDR_W             registered address to instruction_memory
//  imem_read  out  1                  registered read strobe to instruction_memory
//  imem_data  in   DATA_W             combinational instruction_out from instruction_memory
//  rdata      out  DATA_W             captured word, broadcast to all cores
//  rvalid     out  NUM_CORES          one-hot, one-cycle pulse marking rdata's owner
//  busy       out  1                  a fetch is in flight (|pending)
//  stall_cnt  out  16                 contention counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset (RESET=1 at posedge)
//   - imem_addr, imem_read, rdata, rvalid, pending, stage1_valid, stall_cnt <= 0; rr_ptr <= 0.
//   - Reset mid-flight drops the fetch; no rvalid is ever produced for it.
//  Pipeline: 2 stages, fixed latency of 2 cycles from request to rvalid.
//   - Cycle T, arbitrate:
//     - eligible = req & ~pending; winner w = first set bit of eligible at or after rr_ptr, wrapping NUM_CORES-1 -> 0.
//     - If eligible != 0: imem_addr <= req_addr[w], imem_read <= 1, pending[w] <= 1, sel <= w, stage1_valid <= 1,
//       rr_ptr <= (w == NUM_CORES-1) ? 0 : w+1.
//     - Else: imem_read <= 0, stage1_valid <= 0; rr_ptr holds.
//   - Cycle T+1, capture: if stage1_valid, rdata <= imem_data, rvalid <= (1 << sel), pending[sel] <= 0;
//     otherwise rvalid <= 0 and rdata holds.
//   - Cycle T+2: rvalid[w] = 1 for exactly one cycle.
//  Throughput: at most one grant per cycle overall and one fetch per 2 cycles per core.
//  Request rules:
//   - A core whose rvalid is high may keep req high with a new req_addr in that same cycle.
//     That is a new request, eligible immediately because pending was cleared at the same edge.
//   - req dropped after the grant: the fetch completes and rvalid still pulses (no cancel).
//   - req dropped before any grant: the request is withdrawn; nothing is issued for it.
//  Boundary conditions:
//   - A capture and a new grant to a different core in the same cycle are both performed.
//   - pending set and clear never target the same core in one cycle (a pending core is ineligible).
//   - Unused upper req bits beyond NUM_CORES do not exist; rr_ptr width = clog2(NUM_CORES).
// CONFIGURATION
//  Macro IMEM_ARB_STATS_EN:
//   - Defined: stall_cnt increments in each cycle where popcount(eligible) >= 2 and saturates at 16'hFFFF.
//     Reset clears it.
//   - Undefined: stall_cnt is tied to 16'h0000 and no counter logic is built.
//  The port list is identical in both configurations.
// STRUCTURE
//  Package imem_arb_pkg:
//   - localparams IMEM_ADDR_W=16, IMEM_DATA_W=16, MAX_CORES=10, STALL_CNT_W=16.
//   - function onehot_of(idx) returning a NUM_CORES-wide one-hot.
//  Sub-module rr_pick:
//   - Purely combinational: (eligible, rr_ptr) -> (any, winner index), implemented as a rotate / priority-encode / un-rotate.
//  imem_fetch_arbiter holds the stage registers, pending vector, rr_ptr and the stats counter.
// TESTING (NUM_CORES=4, memory model returns {8'hA5, addr[7:0]})
//  1. RESET high for 2 cycles -> all outputs 0, busy=0; after release with req=0, imem_read stays 0.
//  2. Single fetch: req=4'b0001, addr0=16'h0010 at T
//     -> T+1: imem_addr=16'h0010, imem_read=1; T+2: rvalid=4'b0001, rdata=16'hA510.
//  3. req=4'b1111 held, every core changes addr on its own rvalid
//     -> grants issue in order 0,1,2,3,0,... one per cycle.
//     -> Each rvalid is one-hot, each rdata matches that core's address; with STATS_EN stall_cnt rises.
//  4. Core 2 alone, req held, addr incremented on each rvalid -> rvalid[2] every 2nd cycle, sequential rdata.
//  5. Grant to core 1 at T, RESET=1 at T+1 -> rvalid stays 0 through T+3; pending=0, rr_ptr=0.
//  6. Grant to core 3 at T, req[3] dropped at T+1 -> rvalid=4'b1000 at T+2; no second issue for core 3.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared widths and helpers for the instruction-memory fetch arbiter.
// Combinational only; no latency.
// No flow control.
package imem_arb_pkg;
  localparam int IMEM_ADDR_W = 16;
  localparam int IMEM_DATA_W = 16;
  localparam int MAX_CORES   = 10;
  localparam int STALL_CNT_W = 16;
  localparam int IDX_W       = $clog2(MAX_CORES);

  // Callers truncate the MAX_CORES-wide result to their own core count.
  function automatic logic [MAX_CORES-1:0] onehot_of(input logic [IDX_W-1:0] idx);
    onehot_of = {{(MAX_CORES-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/imem_fetch_arbiter_rr_pick.sv
// Round-robin pick: first eligible core at or after rr_ptr, wrapping to 0.
// Purely combinational, zero latency.
// No flow control; the caller gates eligibility.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] rr_ptr,
  output logic          any,
  output logic [PW-1:0] winner
);
  logic [N-1:0] rot;
  int           off;
  int           sum;

  always_comb begin
    rot = '0;
    off = 0;
    sum = 0;
    // Rotate so rr_ptr lands at bit 0, take the lowest set bit, rotate back.
    for (int i = 0; i < N; i++) begin
      rot[i] = eligible[PW'((i + int'(rr_ptr) >= N) ? i + int'(rr_ptr) - N : i + int'(rr_ptr))];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    sum = off + int'(rr_ptr);
    if (sum >= N) sum = sum - N;
    winner = PW'(sum);
    any    = |eligible;
  end
endmodule

// File: rtl/imem_fetch_arbiter.sv
// Round-robin share of the instruction_memory read port; optional IMEM_ARB_STATS_EN builds the stall counter.
// Latency: 2 cycles from request to one-hot rvalid; one grant per cycle overall.
// Backpressure: a core holds req until its rvalid; a pending core is not re-granted.
module imem_fetch_arbiter
  import imem_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int DATA_W    = IMEM_DATA_W
) (
  input  logic                        clk,
  input  logic                        RESET,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0]           imem_addr,
  output logic                        imem_read,
  input  logic [DATA_W-1:0]           imem_data,
  output logic [DATA_W-1:0]           rdata,
  output logic [NUM_CORES-1:0]        rvalid,
  output logic                        busy,
  output logic [STALL_CNT_W-1:0]      stall_cnt
);
  localparam int PW = $clog2(NUM_CORES);

  logic [NUM_CORES-1:0] pending;
  logic [NUM_CORES-1:0] pending_nxt;
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] win_oh;
  logic [NUM_CORES-1:0] sel_oh;
  logic                 stage1_valid;
  logic [PW-1:0]        sel;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        win;
  logic                 any;

  assign eligible = req & ~pending;
  assign busy     = |pending;
  assign win_oh   = NUM_CORES'(onehot_of(IDX_W'(win)));
  assign sel_oh   = NUM_CORES'(onehot_of(IDX_W'(sel)));

  rr_pick #(.N(NUM_CORES), .PW(PW)) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .any      (any),
    .winner   (win)
  );

  // Set and clear never hit the same core: a pending core is never eligible.
  always_comb begin
    pending_nxt = pending;
    if (stage1_valid) pending_nxt = pending_nxt & ~sel_oh;
    if (any)          pending_nxt = pending_nxt | win_oh;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      imem_addr    <= '0;
      imem_read    <= 1'b0;
      rdata        <= '0;
      rvalid       <= '0;
      pending      <= '0;
      stage1_valid <= 1'b0;
      sel          <= '0;
      rr_ptr       <= '0;
    end else begin
      pending <= pending_nxt;
      rvalid  <= stage1_valid ? sel_oh : '0;
      if (stage1_valid) rdata <= imem_data;
      if (any) begin
        imem_addr    <= req_addr[int'(win)*ADDR_W +: ADDR_W];
        imem_read    <= 1'b1;
        sel          <= win;
        stage1_valid <= 1'b1;
        rr_ptr       <= (int'(win) == NUM_CORES - 1) ? '0 : win + 1'b1;
      end else begin
        imem_read    <= 1'b0;
        stage1_valid <= 1'b0;
      end
    end
  end

`ifdef IMEM_ARB_STATS_EN
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   contention;

  // Two or more eligible bits: clearing the lowest one leaves something set.
  assign contention = |(eligible & (eligible - NUM_CORES'(1)));

  always_ff @(posedge clk) begin
    if (RESET)                              stall_q <= '0;
    else if (contention && (stall_q != '1)) stall_q <= stall_q + 1'b1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif
endmodule
